// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the baud
// divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Rounded clocks-per-tick divisor.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks, with a
// synchronous clear so the phase can be aligned to an external event.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rx, samples each bit at mid-bit
// and emits one character per frame with a valid strobe and error flags.
import uart_pkg::*;

module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_os: CLK_FREQ/(BAUD*OVERSAMPLE) rounds below 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_os: OVERSAMPLE must be even and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_par_chk
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  rx_state_e            r_state;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_acc;
  logic                 r_ferr_acc;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_busy;

  logic w_fall;
  logic w_clr;
  logic w_tick;
  logic w_bit_end;
  logic w_par_xor;
  logic w_ferr_now;

  assign w_fall     = r_prev & ~r_sync2;
  assign w_clr      = (r_state == ST_IDLE) && w_fall;
  assign w_bit_end  = w_tick && (r_tcnt == BIT_LAST);
  assign w_par_xor  = (^r_shift) ^ r_sync2;
  assign w_ferr_now = r_ferr_acc | ~r_sync2;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tcnt     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_tcnt     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tcnt == HALF_LAST) begin
              r_tcnt <= '0;
              if (!r_sync2) begin
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == BIT_LAST) begin
              r_tcnt <= '0;
              // Shifting in from the top leaves the first bit at [0] after DATA_BITS samples.
              r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
              if (r_bit_idx == DATA_LAST) begin
                r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_bit_end) begin
              r_tcnt     <= '0;
              r_perr_acc <= (PARITY == PAR_EVEN) ? w_par_xor : ~w_par_xor;
              r_state    <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (w_bit_end) begin
              r_tcnt <= '0;
              if (r_stop_idx == STOP_LAST) begin
                r_data  <= r_shift;
                r_perr  <= r_perr_acc;
                r_ferr  <= w_ferr_now;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_stop_idx <= 1'b1;
                r_ferr_acc <= w_ferr_now;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed and randomized frames driven into three receiver configurations
// (8N1, 8E1, 5N2), compared against a character-level reference queue.
`timescale 1ns/1ps
module tb_uart_rx_os;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_b;
  logic [4:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

  uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

  uart_rx_os #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16),
               .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .data(data_c), .valid(valid_c),
    .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

  // 10 ns clock: DIV=27 -> 432 clocks/bit; DIV=4 -> 64 clocks/bit.
  localparam real BIT_AB = 4320.0;
  localparam real BIT_C  = 640.0;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } ch_t;

  ch_t expq[$];
  ch_t obsq[$];
  int  vectors = 0;
  int  miscompares = 0;

  always @(negedge clk) begin
    if (valid_a) obsq.push_back(ch_t'({2'd0, 1'b0, data_a, perr_a, ferr_a}));
    if (valid_b) obsq.push_back(ch_t'({2'd1, 1'b0, data_b, perr_b, ferr_b}));
    if (valid_c) obsq.push_back(ch_t'({2'd2, 4'd0, data_c, perr_c, ferr_c}));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // pbit is only used by the even-parity receiver (which==1).
  task automatic send_frame(input int which, input int value, input int pbit,
                            input int stop_low, input real bit_ns, input bit expect_it);
    int  nb;
    int  ns;
    int  mask;
    ch_t e;
    nb   = (which == 2) ? 5 : 8;
    ns   = (which == 2) ? 2 : 1;
    mask = (1 << nb) - 1;
    set_rx(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < nb; i++) begin
      set_rx(which, 1'((value >> i) & 1));
      #(bit_ns);
    end
    if (which == 1) begin
      set_rx(which, 1'(pbit));
      #(bit_ns);
    end
    for (int s = 0; s < ns; s++) begin
      set_rx(which, ((stop_low >> s) & 1) != 0 ? 1'b0 : 1'b1);
      #(bit_ns);
    end
    set_rx(which, 1'b1);
    if (expect_it) begin
      e.id = 2'(which);
      e.d  = 9'(value & mask);
      e.pe = (which == 1) ? 1'((($countones(value & mask) + pbit) % 2)) : 1'b0;
      e.fe = ((stop_low & ((1 << ns) - 1)) != 0);
      expq.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(obsq.size()), 32'(expq.size()));
    while (expq.size() > 0 && obsq.size() > 0) begin
      chk(tag, 32'(obsq.pop_front()), 32'(expq.pop_front()));
    end
    expq.delete();
    obsq.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish (vectors %0d)", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    int p;
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 32'({data_a, valid_a, perr_a, ferr_a, busy_a}), 32'd0);
    chk("reset_c", 32'({data_c, valid_c, perr_c, ferr_c, busy_c}), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 directed and random characters
    send_frame(0, 'hA5, 0, 0, BIT_AB, 1'b1);
    repeat (20) @(negedge clk);
    check_all("a_A5");
    chk("a_busy_idle", 32'(busy_a), 32'd0);
    for (int k = 0; k < 2; k++) begin
      v = int'($urandom_range(0, 255));
      send_frame(0, v, 0, 0, BIT_AB, 1'b1);
    end
    repeat (20) @(negedge clk);
    check_all("a_rand");

    // false start: low for ~4 ticks, then high
    @(negedge clk);
    set_rx(0, 1'b0);
    repeat (50) @(negedge clk);
    chk("fs_busy_hi", 32'(busy_a), 32'd1);
    repeat (58) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (122) @(negedge clk);
    chk("fs_busy_lo", 32'(busy_a), 32'd0);
    repeat (500) @(negedge clk);
    check_all("fs_nostrobe");

    // stop bit low
    send_frame(0, 'h55, 0, 1, BIT_AB, 1'b1);
    #(BIT_AB);
    check_all("a_frame_err");
    chk("a_hold_ferr", 32'(ferr_a), 32'd1);

    // reset mid-DATA; remaining bits of 0xFC are all 1 so no new edge follows
    fork
      send_frame(0, 'hFC, 0, 0, BIT_AB, 1'b0);
      begin
        #(BIT_AB * 3.5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_reset_a", 32'({data_a, valid_a, perr_a, ferr_a, busy_a}), 32'd0);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check_all("a_discard");
    send_frame(0, 'h3C, 0, 0, BIT_AB, 1'b1);
    repeat (20) @(negedge clk);
    check_all("a_3C");

    // even parity
    send_frame(1, 'h03, 1, 0, BIT_AB, 1'b1);
    send_frame(1, 'h03, 0, 0, BIT_AB, 1'b1);
    repeat (20) @(negedge clk);
    check_all("b_par_dir");
    for (int k = 0; k < 3; k++) begin
      v = int'($urandom_range(0, 255));
      p = int'($urandom_range(0, 1));
      send_frame(1, v, p, 0, BIT_AB, 1'b1);
    end
    repeat (20) @(negedge clk);
    check_all("b_par_rand");

    // 5N2, transmitter 2% fast, back-to-back
    for (int k = 0; k < 32; k += 2) begin
      send_frame(2, k, 0, 0, BIT_C * 0.98, 1'b1);
    end
    #(2 * BIT_C);
    check_all("c_b2b");
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(0, 31));
      p = int'($urandom_range(0, 3));
      send_frame(2, v, 0, p, BIT_C, 1'b1);
      #(2 * BIT_C);
    end
    check_all("c_rand");

    // break: five frame times low
    set_rx(2, 1'b0);
    #(5 * 8 * BIT_C);
    set_rx(2, 1'b1);
    #(3 * BIT_C);
    expq.push_back(ch_t'({2'd2, 9'd0, 1'b0, 1'b1}));
    check_all("c_break");
    chk("c_busy_idle", 32'(busy_c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver; successor to the fixed 8-bit sample-per-clock receiver. It synchronises the asynchronous `rx` line and generates its own baud timing from the system clock. Each bit is sampled at mid-bit, with start-bit validation and configurable data width, parity and stop bits. It delivers each received character with a one-cycle `valid` strobe and per-character error flags to the UART-to-flash command path.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency, Hz.
- `BAUD`, 115200: line rate, bit/s.
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥4.
- `DATA_BITS`, 8: character width, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `clk  in  1`: system clock, all logic on rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `rx  in  1`: asynchronous serial input, idle high.
- `data  out  DATA_BITS`: last received character, LSB received first.
- `valid  out  1`: one-cycle strobe; `data` and error flags are valid in this cycle.
- `parity_err  out  1`: parity mismatch on the current character; always 0 when `PARITY`=0.
- `frame_err  out  1`: at least one stop bit sampled low.
- `busy  out  1`: high while not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, which resets to 1, then a 1-flop edge register. A falling edge is prev=1, now=0.
- Tick divisor: `DIV = round(CLK_FREQ / (BAUD*OVERSAMPLE))`. Elaboration fails if `DIV` < 2. `tick` is a one-clock pulse every `DIV` clocks.
- The divider and the tick counter clear on the falling edge in IDLE, so phase is aligned to the start edge.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- **IDLE**: on falling edge, go to START and clear counters.
- **START**: after `OVERSAMPLE/2` ticks, sample the line.
  - Sample 0: go to DATA.
  - Sample 1: false start; go to IDLE with no flags and no strobe.
- **DATA**: sample every `OVERSAMPLE` ticks into `shift[bit_idx]`, LSB first. After `DATA_BITS` samples, go to PARITY if `PARITY`≠0, otherwise STOP.
- **PARITY**: one sample.
  - Even parity: error if the XOR of data bits and the parity bit is 1.
  - Odd parity: error if that XOR is 0.
- **STOP**: `STOP_BITS` samples, each one bit period apart. `frame_err` is the OR of "sample==0" across them.
  - After the last stop sample, in the same clock: load `data`, set the flags, assert `valid`, go to IDLE.
- IDLE re-arms at mid-stop-bit. The next start edge is accepted from that point, which tolerates a fast transmitter clock.
- Break (rx held low) yields exactly one character with `data`=0 and `frame_err`=1. No further character follows until the line has been high, because a falling edge is required.
- `data`, `parity_err` and `frame_err` hold their values until the next `valid`.
- Reset, including mid-frame: state IDLE, counters 0, `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, synchroniser flops=1. A partial frame is discarded.

## Timing
- `rx` edge to FSM visibility: 3 clocks (2 synchroniser flops + edge register).
- Sample points: `OVERSAMPLE/2 + k*OVERSAMPLE` ticks after the start edge, ±1 clock quantisation.
- `valid` is high for exactly 1 clock, in the clock after the final stop-bit tick. Latency from the start edge is about (1+DATA_BITS+P+STOP_BITS−0.5) bit periods + 4 clocks, where P=1 with parity, 0 without.
- `busy` rises 1 clock after the edge is detected and falls in the same cycle `valid` asserts. It also falls on a false start.
- No backpressure: the consumer must accept `valid` in its cycle. A new character overwrites `data`.
- Tolerated baud mismatch: ±3% at `OVERSAMPLE`=16, 10-bit frame.

## Structure
- Shared package `uart_pkg` holds:
  - parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - FSM state encoding;
  - function `baud_div(clk_freq, baud, os)`, reused by the transmitter.
- Sub-module `uart_baud_tick`: parameter `DIV`; ports `clk`, `rst_n`, `clr`, `tick`.
- FSM, counters, shift register and synchroniser stay in `uart_rx_os`.

## Test plan
- Default parameters (DIV=27), send 8N1 0xA5 → one `valid` pulse, `data`=0xA5, both errors 0, `busy` low afterwards.
- Pull `rx` low for 4 bit-ticks (~108 clocks), then high → no `valid`, `busy` back to 0 within `OVERSAMPLE/2` ticks + 4 clocks.
- `PARITY`=2, send 0x03 with parity bit 1 → `valid`, `data`=0x03, `parity_err`=1. With parity bit 0 → `parity_err`=0.
- Stop bit driven 0 on 0x55 → `frame_err`=1, `data`=0x55. Hold `rx` low for 5 frame times → exactly one `valid` with `data`=0x00 and `frame_err`=1.
- Assert `rst_n`=0 for 2 clocks mid-DATA → all outputs 0, no `valid`. The next frame 0x3C is received correctly.
- `DATA_BITS`=5, `STOP_BITS`=2, transmitter 2% fast, 16 back-to-back frames 0x00..0x1F step 2 → 16 `valid` pulses with matching data and no errors.
